decode_ctrl_stage: RTL

Registered decode/control stage for the 5-stage MIPS pipeline, replacing the purely combinational controller plus the ad-hoc ID/EX control registers. It decodes the D-stage instruction, registers the control bundle into the E stage, and generates the D-stage stall for two hazards: load-use, and access to a busy multiply/divide unit. Multiply and divide latencies are parameters, so the stage tracks the MD unit's busy window internally.

---
 rtl/ctrl_pkg.sv | 109 ++++++++++
 rtl/decode_ctrl_stage_decode.sv | 117 +++++++++++
 rtl/decode_ctrl_stage.sv | 103 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode constants and the E-stage control bundle for decode_ctrl_stage.
package ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_COP0   = 6'h10;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_ERET  = 6'h18;

    // REGIMM rt selectors and COP0 rs selectors
    localparam logic [4:0] RT_BLTZ = 5'h00;
    localparam logic [4:0] RT_BGEZ = 5'h01;
    localparam logic [4:0] CP0_MF  = 5'h00;
    localparam logic [4:0] CP0_MT  = 5'h04;
    localparam logic [4:0] CP0_CO  = 5'h10;

    // ALU operations
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_LUI  = 4'b0111;
    localparam logic [3:0] ALU_MOVE = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLLV = 4'b1010;
    localparam logic [3:0] ALU_SRAV = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRLV = 4'b1101;

    // Multiply/divide unit operations
    localparam logic [3:0] MD_MULT  = 4'b0000;
    localparam logic [3:0] MD_MULTU = 4'b0001;
    localparam logic [3:0] MD_DIV   = 4'b0010;
    localparam logic [3:0] MD_DIVU  = 4'b0011;
    localparam logic [3:0] MD_MFHI  = 4'b0100;
    localparam logic [3:0] MD_MFLO  = 4'b0101;
    localparam logic [3:0] MD_MTHI  = 4'b0110;
    localparam logic [3:0] MD_MTLO  = 4'b0111;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       zero_ext;
        logic [3:0] alu_op;
        logic [3:0] md_op;
        logic       md_start;   // starts a multi-cycle mult/div
        logic [4:0] dst;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // MD busy tracker: the counter value is the state, this is its view
    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

endpackage

// File: rtl/decode_ctrl_stage_decode.sv
// instr_decode: combinational D-stage decoder, instruction -> control bundle.
// With CTRL_ILLEGAL_EN defined, unknown encodings are flagged as illegal;
// otherwise they decode as a nop.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_is_md
);

    logic [5:0] w_op, w_funct;
    logic [4:0] w_rs, w_rt, w_rd;
    logic       w_bad, w_wr_rd, w_wr_rt;
    logic       w_unused_shamt;

    assign w_op    = i_instr[31:26];
    assign w_rs    = i_instr[25:21];
    assign w_rt    = i_instr[20:16];
    assign w_rd    = i_instr[15:11];
    assign w_funct = i_instr[5:0];
    // shamt is consumed by the ALU datapath, not by control decode
    assign w_unused_shamt = ^i_instr[10:6];

    // Decode opcode/funct into the bundle; destination chosen after the case
    always_comb begin
        o_ctrl  = CTRL_NOP;
        o_is_md = 1'b0;
        w_bad   = 1'b0;
        w_wr_rd = 1'b0;
        w_wr_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD, F_ADDU: begin o_ctrl.alu_op = ALU_ADD;  w_wr_rd = 1'b1; end
                    F_SUB, F_SUBU: begin o_ctrl.alu_op = ALU_SUB;  w_wr_rd = 1'b1; end
                    F_AND:  begin o_ctrl.alu_op = ALU_AND;  w_wr_rd = 1'b1; end
                    F_OR:   begin o_ctrl.alu_op = ALU_OR;   w_wr_rd = 1'b1; end
                    F_XOR:  begin o_ctrl.alu_op = ALU_XOR;  w_wr_rd = 1'b1; end
                    F_NOR:  begin o_ctrl.alu_op = ALU_NOR;  w_wr_rd = 1'b1; end
                    F_SLL:  begin o_ctrl.alu_op = ALU_SLL;  w_wr_rd = 1'b1; end
                    F_SRL:  begin o_ctrl.alu_op = ALU_SRL;  w_wr_rd = 1'b1; end
                    F_SRA:  begin o_ctrl.alu_op = ALU_SRA;  w_wr_rd = 1'b1; end
                    F_SLLV: begin o_ctrl.alu_op = ALU_SLLV; w_wr_rd = 1'b1; end
                    F_SRLV: begin o_ctrl.alu_op = ALU_SRLV; w_wr_rd = 1'b1; end
                    F_SRAV: begin o_ctrl.alu_op = ALU_SRAV; w_wr_rd = 1'b1; end
                    F_JR:   ;
                    F_JALR: w_wr_rd = 1'b1;
                    F_MFHI: begin o_ctrl.md_op = MD_MFHI; o_is_md = 1'b1; w_wr_rd = 1'b1; end
                    F_MFLO: begin o_ctrl.md_op = MD_MFLO; o_is_md = 1'b1; w_wr_rd = 1'b1; end
                    F_MTHI: begin o_ctrl.md_op = MD_MTHI; o_is_md = 1'b1; end
                    F_MTLO: begin o_ctrl.md_op = MD_MTLO; o_is_md = 1'b1; end
                    F_MULT:  begin o_ctrl.md_op = MD_MULT;  o_ctrl.md_start = 1'b1; o_is_md = 1'b1; end
                    F_MULTU: begin o_ctrl.md_op = MD_MULTU; o_ctrl.md_start = 1'b1; o_is_md = 1'b1; end
                    F_DIV:   begin o_ctrl.md_op = MD_DIV;   o_ctrl.md_start = 1'b1; o_is_md = 1'b1; end
                    F_DIVU:  begin o_ctrl.md_op = MD_DIVU;  o_ctrl.md_start = 1'b1; o_is_md = 1'b1; end
                    default: w_bad = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin o_ctrl.alu_op = ALU_ADD; o_ctrl.alu_src = 1'b1; w_wr_rt = 1'b1; end
            OP_ANDI: begin o_ctrl.alu_op = ALU_AND; o_ctrl.alu_src = 1'b1; o_ctrl.zero_ext = 1'b1; w_wr_rt = 1'b1; end
            OP_ORI:  begin o_ctrl.alu_op = ALU_OR;  o_ctrl.alu_src = 1'b1; o_ctrl.zero_ext = 1'b1; w_wr_rt = 1'b1; end
            OP_XORI: begin o_ctrl.alu_op = ALU_XOR; o_ctrl.alu_src = 1'b1; o_ctrl.zero_ext = 1'b1; w_wr_rt = 1'b1; end
            OP_LUI:  begin o_ctrl.alu_op = ALU_LUI; o_ctrl.alu_src = 1'b1; w_wr_rt = 1'b1; end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                w_wr_rt           = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_ctrl.alu_op = ALU_SUB;
            OP_REGIMM: begin
                if (w_rt == RT_BLTZ || w_rt == RT_BGEZ) o_ctrl.alu_op = ALU_SUB;
                else                                     w_bad = 1'b1;
            end
            OP_J:   ;
            OP_JAL: begin o_ctrl.reg_write = 1'b1; o_ctrl.dst = 5'd31; end
            OP_COP0: begin
                if (w_rs == CP0_MF) begin
                    o_ctrl.alu_op = ALU_MOVE;
                    w_wr_rt       = 1'b1;
                end else if (w_rs == CP0_MT) begin
                    o_ctrl.alu_op = ALU_MOVE;
                end else if (!(w_rs == CP0_CO && w_funct == F_ERET)) begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b1;
        endcase

        if (w_wr_rd) begin
            o_ctrl.reg_dst   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.dst       = w_rd;
        end
        if (w_wr_rt) begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.dst       = w_rt;
        end

`ifdef CTRL_ILLEGAL_EN
        if (w_bad) begin
            o_ctrl         = CTRL_NOP;
            o_ctrl.illegal = 1'b1;
        end
`else
        if (w_bad) o_ctrl = CTRL_NOP;
`endif
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered ID->EX control stage with load-use and
// MD-busy stall generation. Optional macro CTRL_ILLEGAL_EN enables the
// illegal-instruction flag (decoder drives it to 0 when undefined).
module decode_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic        flush,
    output logic        stall_d,
    output logic        e_valid,
    output logic        e_reg_dst,
    output logic        e_alu_src,
    output logic        e_mem_to_reg,
    output logic        e_reg_write,
    output logic        e_mem_read,
    output logic        e_mem_write,
    output logic        e_zero_ext,
    output logic [3:0]  e_alu_op,
    output logic [3:0]  e_md_op,
    output logic        e_md_start,
    output logic [4:0]  e_dst,
    output logic        md_busy,
    output logic        e_illegal
);

    ctrl_t      w_dec, r_e;
    logic       w_is_md, r_e_valid;
    logic       w_load_use, w_md_stall, w_issue;
    logic [5:0] r_md_cnt, w_md_cnt_nxt;
    md_state_e  w_md_state;

    instr_decode u_dec (
        .i_instr (instr_d),
        .o_ctrl  (w_dec),
        .o_is_md (w_is_md)
    );

    assign w_md_state = (r_md_cnt != 6'd0) ? MD_BUSY : MD_IDLE;
    assign md_busy    = (w_md_state == MD_BUSY);

    // A load in E whose destination feeds either source field of D must wait one cycle
    assign w_load_use = r_e_valid && r_e.mem_read && (r_e.dst != 5'd0) && valid_d &&
                        ((r_e.dst == instr_d[25:21]) || (r_e.dst == instr_d[20:16]));
    assign w_md_stall = w_is_md && md_busy;
    assign stall_d    = w_load_use || w_md_stall;
    assign w_issue    = valid_d && !stall_d && !flush;

    // ID/EX register: decoded bundle on issue, bubble otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e       <= CTRL_NOP;
            r_e_valid <= 1'b0;
        end else if (w_issue) begin
            r_e       <= w_dec;
            r_e_valid <= 1'b1;
        end else begin
            r_e       <= CTRL_NOP;
            r_e_valid <= 1'b0;
        end
    end

    // MD busy counter state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_md_cnt <= 6'd0;
        else          r_md_cnt <= w_md_cnt_nxt;
    end

    // Counter next state: count down while busy; reload when a mult/div issues.
    // A later flush of that op does not cancel the window.
    always_comb begin
        w_md_cnt_nxt = r_md_cnt;
        case (w_md_state)
            MD_IDLE: w_md_cnt_nxt = 6'd0;
            MD_BUSY: w_md_cnt_nxt = r_md_cnt - 6'd1;
            default: w_md_cnt_nxt = 6'd0;
        endcase
        if (w_issue && w_dec.md_start) begin
            if (w_dec.md_op == MD_DIV || w_dec.md_op == MD_DIVU) w_md_cnt_nxt = 6'(DIV_LAT);
            else                                                  w_md_cnt_nxt = 6'(MULT_LAT);
        end
    end

    assign e_valid      = r_e_valid;
    assign e_reg_dst    = r_e.reg_dst;
    assign e_alu_src    = r_e.alu_src;
    assign e_mem_to_reg = r_e.mem_to_reg;
    assign e_reg_write  = r_e.reg_write;
    assign e_mem_read   = r_e.mem_read;
    assign e_mem_write  = r_e.mem_write;
    assign e_zero_ext   = r_e.zero_ext;
    assign e_alu_op     = r_e.alu_op;
    assign e_md_op      = r_e.md_op;
    assign e_md_start   = r_e.md_start;
    assign e_dst        = r_e.dst;
    assign e_illegal    = r_e.illegal;

endmodule
